mire_writer: RTL

Wishbone write master that fills the SDRAM framebuffer with a grid test pattern, one 32-bit word per pixel, at word addresses 0 to HDISP*VDISP-1. It sits upstream of the VGA display controller: it produces the framebuffer contents that the display controller reads back over Wishbone and streams to the screen. It shares the SDRAM with the display controller through the Wishbone interconnect arbiter. It releases the bus periodically so the display reader is never starved.

---
 rtl/mire_pkg.sv | 24 ++
 rtl/mire_pos_counter.sv | 58 +++++
 rtl/mire_writer.sv | 112 +++++++++++
 3 files changed

// File: rtl/mire_pkg.sv
// Shared types and helpers for the mire_writer grid test-pattern generator.
package mire_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_YIELD,
        ST_DONE
    } state_e;

    localparam logic [31:0] PIX_WHITE = 32'h00FF_FFFF;
    localparam logic [31:0] PIX_BLACK = 32'h0000_0000;

    // grid is a power of two, so "mod grid" reduces to a mask
    function automatic logic [31:0] grid_pixel(input int unsigned x, input int unsigned y,
                                               input int unsigned hdisp, input int unsigned vdisp,
                                               input int unsigned grid);
        logic on_line;
        on_line = ((x & (grid - 1)) == 0) || ((y & (grid - 1)) == 0) ||
                  (x == hdisp - 1) || (y == vdisp - 1);
        return on_line ? PIX_WHITE : PIX_BLACK;
    endfunction

endpackage

// File: rtl/mire_pos_counter.sv
// Raster position counters: x, y and the linear pixel index, stepped per accepted write.
module mire_pos_counter #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int XW    = $clog2(HDISP),
    parameter int YW    = $clog2(VDISP),
    parameter int IW    = $clog2(HDISP * VDISP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [IW-1:0] idx,
    output logic          eol,
    output logic          last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [IW-1:0] idx_q, idx_d;

    assign eol  = (x_q == XW'(HDISP - 1));
    assign last = eol && (y_q == YW'(VDISP - 1));

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        idx_d = idx_q;
        if (clr) begin
            x_d   = '0;
            y_d   = '0;
            idx_d = '0;
        end else if (adv) begin
            x_d   = eol ? '0 : x_q + 1'b1;
            idx_d = last ? '0 : idx_q + 1'b1;
            if (eol) y_d = last ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            idx_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            idx_q <= idx_d;
        end
    end

    assign x   = x_q;
    assign y   = y_q;
    assign idx = idx_q;

endmodule

// File: rtl/mire_writer.sv
// Wishbone write master filling the framebuffer with a grid pattern, releasing the bus every BURST acks.
// MIRE_CONTINUOUS_EN: when defined, frames are rewritten back to back without a new start.
module mire_writer
    import mire_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64,
    parameter int GRID  = 16
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic        ack,
    input  logic [31:0] dat_sm
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int IW = $clog2(HDISP * VDISP);
    localparam int BW = $clog2(BURST);

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          adv, clr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [IW-1:0] idx;
    logic          eol, last;
    logic          unused_dat;

    assign unused_dat = ^dat_sm;

    mire_pos_counter #(
        .HDISP(HDISP), .VDISP(VDISP), .XW(XW), .YW(YW), .IW(IW)
    ) u_pos (
        .clk  (wshb_clk),
        .rst_n(wshb_rst_n),
        .adv  (adv),
        .clr  (clr),
        .x    (x),
        .y    (y),
        .idx  (idx),
        .eol  (eol),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        adv     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_WRITE;
            ST_WRITE: begin
                // ack only counts while the strobe is up, which is exactly this state
                if (ack) begin
                    adv     = 1'b1;
                    burst_d = burst_q + 1'b1;
                    if (last)                            state_d = ST_DONE;
                    else if (burst_q == BW'(BURST - 1)) state_d = ST_YIELD;
                end
            end
            ST_YIELD: begin
                burst_d = '0;
                state_d = ST_WRITE;
            end
            ST_DONE: begin
                burst_d = '0;
                clr     = 1'b1;
`ifdef MIRE_CONTINUOUS_EN
                state_d = ST_WRITE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    assign cyc        = (state_q == ST_WRITE);
    assign stb        = cyc;
    assign busy       = (state_q == ST_WRITE) || (state_q == ST_YIELD);
    assign frame_done = (state_q == ST_DONE);
    assign we         = 1'b1;
    assign sel        = 4'hF;
    assign cti        = 3'd0;
    assign bte        = 2'd0;
    assign adr        = 32'(idx) << 2;
    assign dat_ms     = grid_pixel(32'(x), 32'(y), HDISP, VDISP, GRID);

endmodule
